// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: states, opcodes,
// ALU op classes and the mux select codes driven to the datapath.
package multicycle_pkg;

    localparam int unsigned OP_W   = 7;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned ALUC_W = 3;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        JAL,
        BEQ
    } statetype_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;

    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_WD    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface multicycle_controller_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [2:0] alucontrol;
    logic       adrsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;

    modport master (
        input  op, funct3, funct7b5, zero,
        output immsrc, alusrca, alusrcb, resultsrc, alucontrol,
               adrsrc, irwrite, pcwrite, regwrite, memwrite
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  immsrc, alusrca, alusrcb, resultsrc, alucontrol,
               adrsrc, irwrite, pcwrite, regwrite, memwrite
    );

endinterface

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps the FSM's ALU op class plus instruction fields to alucontrol.
module aludec
    import multicycle_pkg::*;
(
    input  aluop_t            aluop,
    input  logic [F3_W-1:0]   funct3,
    input  logic              op5,
    input  logic              funct7b5,
    output logic [ALUC_W-1:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        unique case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                // sub only for R-type with funct7[5]; addi always adds
                unique case (funct3)
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM sequencing the shared multicycle datapath; outputs are
// decoded from the state register, with pcwrite also gated by the ALU zero flag.
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    statetype_t       state, state_n;
    aluop_t           aluop;
    logic             pcupdate, branch;
    logic [SEL_W-1:0] alusrca, alusrcb, resultsrc, immsrc;
    logic             adrsrc, irwrite, regwrite, memwrite;
    logic [ALUC_W-1:0] alucontrol;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_n;
    end

    // next state and state-decoded controls
    always_comb begin
        state_n   = FETCH;
        aluop     = ALUOP_ADD;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_WD;
        resultsrc = RES_ALUOUT;
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        unique case (state)
            FETCH: begin
                irwrite   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURES;
                pcupdate  = 1'b1;
                state_n   = DECODE;
            end
            DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                unique case (bus.op)
                    OP_LW, OP_SW: state_n = MEMADR;
                    OP_RTYPE:     state_n = EXECUTER;
                    OP_ITYPE:     state_n = EXECUTEI;
                    OP_JAL:       state_n = JAL;
                    OP_BEQ:       state_n = BEQ;
                    default:      state_n = FETCH;
                endcase
            end
            MEMADR: begin
                alusrca = SRCA_RD1;
                alusrcb = SRCB_IMM;
                state_n = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adrsrc  = 1'b1;
                state_n = MEMWB;
            end
            MEMWB: begin
                resultsrc = RES_DATA;
                regwrite  = 1'b1;
            end
            MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTER: begin
                alusrca = SRCA_RD1;
                aluop   = ALUOP_FUNCT;
                state_n = ALUWB;
            end
            EXECUTEI: begin
                alusrca = SRCA_RD1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
                state_n = ALUWB;
            end
            ALUWB: regwrite = 1'b1;
            JAL: begin
                alusrca  = SRCA_OLDPC;
                alusrcb  = SRCB_FOUR;
                pcupdate = 1'b1;
                state_n  = ALUWB;
            end
            BEQ: begin
                alusrca = SRCA_RD1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: state_n = FETCH;
        endcase
    end

    // immediate format follows the opcode in every state
    always_comb begin
        immsrc = IMM_I;
        unique case (bus.op)
            OP_SW:   immsrc = IMM_S;
            OP_BEQ:  immsrc = IMM_B;
            OP_JAL:  immsrc = IMM_J;
            default: immsrc = IMM_I;
        endcase
    end

    aludec u_aludec (
        .aluop      (aluop),
        .funct3     (bus.funct3),
        .op5        (bus.op[5]),
        .funct7b5   (bus.funct7b5),
        .alucontrol (alucontrol)
    );

    assign bus.pcwrite    = pcupdate | (branch & bus.zero);
    assign bus.immsrc     = immsrc;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.resultsrc  = resultsrc;
    assign bus.alucontrol = alucontrol;
    assign bus.adrsrc     = adrsrc;
    assign bus.irwrite    = irwrite;
    assign bus.regwrite   = regwrite;
    assign bus.memwrite   = memwrite;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle control words compared against an
// instruction-level model of the control sequence.
module tb_multicycle_controller;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // word = {immsrc, alusrca, alusrcb, resultsrc, alucontrol, adrsrc, irwrite, pcwrite, regwrite, memwrite}
    function automatic logic [15:0] mkword(logic [1:0] imm, logic [1:0] sa, logic [1:0] sb,
                                           logic [1:0] rs, logic [2:0] ac, logic adr,
                                           logic irw, logic pcw, logic rw, logic mw);
        return {imm, sa, sb, rs, ac, adr, irw, pcw, rw, mw};
    endfunction

    function automatic logic [1:0] m_imm(logic [6:0] op);
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] m_funct(logic [6:0] op, logic [2:0] f3, logic f7b5);
        case (f3)
            3'b000:  return (op[5] && f7b5) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int m_len(logic [6:0] op);
        case (op)
            7'b0000011: return 5;
            7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
            7'b1100011: return 3;
            default:    return 2;
        endcase
    endfunction

    // expected control word for cycle c (0 = fetch) of an instruction
    function automatic logic [15:0] m_word(logic [6:0] op, logic [2:0] f3, logic f7b5,
                                           logic z, int c);
        logic [1:0] im;
        logic [2:0] fn;
        im = m_imm(op);
        fn = m_funct(op, f3, f7b5);
        if (c == 0) return mkword(im, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        if (c == 1) return mkword(im, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        case (op)
            7'b0000011: begin
                if (c == 2) return mkword(im, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                if (c == 3) return mkword(im, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                return mkword(im, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            7'b0100011: begin
                if (c == 2) return mkword(im, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return mkword(im, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            7'b0110011: begin
                if (c == 2) return mkword(im, 2'b10, 2'b00, 2'b00, fn, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return mkword(im, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            7'b0010011: begin
                if (c == 2) return mkword(im, 2'b10, 2'b01, 2'b00, fn, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return mkword(im, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            7'b1101111: begin
                if (c == 2) return mkword(im, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                return mkword(im, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            default: // beq
                return mkword(im, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0, z, 1'b0, 1'b0);
        endcase
    endfunction

    function automatic logic [15:0] observed();
        return {bus.immsrc, bus.alusrca, bus.alusrcb, bus.resultsrc, bus.alucontrol,
                bus.adrsrc, bus.irwrite, bus.pcwrite, bus.regwrite, bus.memwrite};
    endfunction

    task automatic check_word(string tag, int c, logic [15:0] exp);
        logic [15:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask

    // zmode: 0 zero low, 1 zero high, 2 random each cycle; ncyc<len stops mid-instruction
    task automatic run_instr(string tag, logic [6:0] op, logic [2:0] f3, logic f7b5,
                             int zmode, int ncyc);
        int len;
        logic z;
        len = m_len(op);
        if (ncyc > 0 && ncyc < len) len = ncyc;
        bus.op = op;
        bus.funct3 = f3;
        bus.funct7b5 = f7b5;
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            z = (zmode == 2) ? 1'($urandom_range(1)) : 1'(zmode);
            bus.zero = z;
            #1;
            check_word(tag, c, m_word(op, f3, f7b5, z, c));
        end
        if (ncyc == 0) @(negedge clk);
    endtask

    logic [6:0] ops [6];
    logic [6:0] rop;

    initial begin
        checks = 0;
        failures = 0;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1101111; ops[5] = 7'b1100011;
        reset = 1'b1;
        bus.op = 7'b0000000;
        bus.funct3 = 3'b000;
        bus.funct7b5 = 1'b0;
        bus.zero = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_word("reset_hold", 0, m_word(7'b0000000, 3'b000, 1'b0, 1'b0, 0));
        @(negedge clk);
        reset = 1'b0;

        run_instr("lw", 7'b0000011, 3'b010, 1'b0, 2, 0);
        run_instr("sw", 7'b0100011, 3'b010, 1'b1, 2, 0);
        run_instr("sub", 7'b0110011, 3'b000, 1'b1, 2, 0);
        run_instr("addi_f7b5", 7'b0010011, 3'b000, 1'b1, 2, 0);
        run_instr("beq_taken", 7'b1100011, 3'b000, 1'b0, 1, 0);
        run_instr("beq_not", 7'b1100011, 3'b000, 1'b0, 0, 0);
        run_instr("jal", 7'b1101111, 3'b101, 1'b0, 2, 0);
        run_instr("undef", 7'b0000000, 3'b000, 1'b0, 2, 0);
        run_instr("slt", 7'b0110011, 3'b010, 1'b0, 0, 0);
        run_instr("ori", 7'b0010011, 3'b110, 1'b0, 0, 0);
        run_instr("and", 7'b0110011, 3'b111, 1'b0, 0, 0);

        // lw interrupted by reset while in MEMREAD
        run_instr("lw_part", 7'b0000011, 3'b010, 1'b0, 0, 4);
        #1 reset = 1'b1;
        #1 check_word("reset_mid", 0, m_word(7'b0000011, 3'b010, 1'b0, 1'b0, 0));
        @(negedge clk);
        #1 check_word("reset_held_edge", 0, m_word(7'b0000011, 3'b010, 1'b0, 1'b0, 0));
        reset = 1'b0;
        run_instr("after_reset", 7'b0100011, 3'b000, 1'b0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(6) == 6) begin
                rop = 7'($urandom);
                while (rop == ops[0] || rop == ops[1] || rop == ops[2] ||
                       rop == ops[3] || rop == ops[4] || rop == ops[5])
                    rop = 7'($urandom);
            end else begin
                rop = ops[$urandom_range(5)];
            end
            run_instr("rand", rop, 3'($urandom), 1'($urandom), 2, 0);
        end
        run_instr("final_fetch", 7'b0000000, 3'b000, 1'b0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
